mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage RV32 pipeline: consumes the EX/MEM pipeline register fields,

---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_access_stage.sv | 150 +++++++++++++++
 tb/tb_mem_access_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access codes, FSM encoding and
// small decode helpers used by the stage and its lane aligner.
package mem_stage_pkg;

    localparam logic [3:0] ACC_NONE = 4'd0;
    localparam logic [3:0] ACC_LB   = 4'd1;
    localparam logic [3:0] ACC_LH   = 4'd2;
    localparam logic [3:0] ACC_LW   = 4'd3;
    localparam logic [3:0] ACC_LBU  = 4'd4;
    localparam logic [3:0] ACC_LHU  = 4'd5;
    localparam logic [3:0] ACC_SB   = 4'd6;
    localparam logic [3:0] ACC_SH   = 4'd7;
    localparam logic [3:0] ACC_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    function automatic logic is_mem_op(input logic [3:0] acc);
        return (acc >= ACC_LB) && (acc <= ACC_SW);
    endfunction

    function automatic logic is_load(input logic [3:0] acc);
        return (acc >= ACC_LB) && (acc <= ACC_LHU);
    endfunction

    // Halfwords need an even address, words a 4-byte-aligned one.
    function automatic logic is_misaligned(input logic [3:0] acc, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (acc)
            ACC_LH, ACC_LHU, ACC_SH: mis = off[0];
            ACC_LW, ACC_SW:          mis = (off != 2'b00);
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: sign/zero extension of load data and store
// strobe generation with lane-replicated write data.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [3:0]  access,
    input  logic [1:0]  off,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    // Halfword selection only looks at off[1]; an odd offset is truncated.
    assign sel_byte = rd_byte[off];
    assign sel_half = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_data = '0;
        wstrb   = '0;
        wdata   = '0;
        case (access)
            ACC_LB:  ld_data = {{24{sel_byte[7]}}, sel_byte};
            ACC_LBU: ld_data = {24'd0, sel_byte};
            ACC_LH:  ld_data = {{16{sel_half[15]}}, sel_half};
            ACC_LHU: ld_data = {16'd0, sel_half};
            ACC_LW:  ld_data = rdata;
            ACC_SB: begin
                wstrb = 4'b0001 << off;
                wdata = {4{wd[7:0]}};
            end
            ACC_SH: begin
                wstrb = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wd[15:0]}};
            end
            ACC_SW: begin
                wstrb = 4'hF;
                wdata = wd;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32 pipeline: req/ready + rvalid handshake to data memory with
// timeout abort. Optional alignment trap enabled by defining MEM_MISALIGN_CHK_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [3:0]  access_in,
    input  logic        we_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wd_in,
    input  logic        pipe_adv,
    output logic        stall_req,
    output logic [31:0] rd_data_out,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
`ifdef MEM_MISALIGN_CHK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_e  state_reg, state_next;
    logic [3:0]  acc_reg;
    logic [31:0] addr_reg;
    logic [31:0] wd_reg;
    logic        we_reg;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] rd_data_reg;
    logic        bus_err_reg;

    logic        start;
    logic        mis_entry;
    logic        timeout;
    logic [31:0] ld_data;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;

    assign start = valid_in & is_mem_op(access_in);

`ifdef MEM_MISALIGN_CHK_EN
    logic misalign_reg;
    assign mis_entry    = start & is_misaligned(access_in, addr_in[1:0]);
    assign misalign_err = misalign_reg;
`else
    assign mis_entry = 1'b0;
`endif

    // A response arriving on the last allowed WAIT cycle still wins over the abort.
    assign timeout = (state_reg == ST_WAIT) & ~mem_rvalid & (cnt_reg == TIMEOUT_LAST);

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (mis_entry)
                    state_next = ST_DONE;
                else if (start)
                    state_next = ST_REQ;
            end
            ST_REQ: begin
                if (mem_ready)
                    state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid || timeout)
                    state_next = ST_DONE;
                else
                    cnt_next = cnt_reg + 8'd1;
            end
            ST_DONE: begin
                if (pipe_adv)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            acc_reg     <= ACC_NONE;
            addr_reg    <= '0;
            wd_reg      <= '0;
            we_reg      <= 1'b0;
            cnt_reg     <= '0;
            rd_data_reg <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bus_err_reg <= timeout;
            if (state_reg == ST_IDLE && start) begin
                acc_reg  <= access_in;
                addr_reg <= addr_in;
                wd_reg   <= wd_in;
                we_reg   <= we_in;
            end
            if (state_reg == ST_WAIT && mem_rvalid) begin
                if (is_load(acc_reg))
                    rd_data_reg <= ld_data;
            end else if (timeout || (state_reg == ST_IDLE && mis_entry)) begin
                rd_data_reg <= '0;
            end
        end
    end

`ifdef MEM_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst)
            misalign_reg <= 1'b0;
        else
            misalign_reg <= (state_reg == ST_IDLE) & mis_entry;
    end
`endif

    mem_lane_align u_lane_align (
        .access  (acc_reg),
        .off     (addr_reg[1:0]),
        .wd      (wd_reg),
        .rdata   (mem_rdata),
        .ld_data (ld_data),
        .wstrb   (st_wstrb),
        .wdata   (st_wdata)
    );

    assign stall_req   = ((state_reg == ST_IDLE) & start) |
                         (state_reg == ST_REQ) | (state_reg == ST_WAIT);
    assign mem_req     = (state_reg == ST_REQ);
    assign mem_we      = we_reg;
    assign mem_addr    = {addr_reg[31:2], 2'b00};
    assign mem_wdata   = st_wdata;
    assign mem_wstrb   = st_wstrb;
    assign rd_data_out = rd_data_reg;
    assign bus_err     = bus_err_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the driver acts as EX/MEM register and data
// memory, the monitor checks requests and completed accesses against queued expectations.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [3:0]  access_in;
    logic        we_in;
    logic [31:0] addr_in;
    logic [31:0] wd_in;
    logic        pipe_adv;
    logic        stall_req;
    logic [31:0] rd_data_out;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef MEM_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    mem_access_stage dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .access_in   (access_in),
        .we_in       (we_in),
        .addr_in     (addr_in),
        .wd_in       (wd_in),
        .pipe_adv    (pipe_adv),
        .stall_req   (stall_req),
        .rd_data_out (rd_data_out),
        .bus_err     (bus_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
`ifdef MEM_MISALIGN_CHK_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
        logic [31:0] rd;
        logic        bus_err;
        logic        mis;
        int          stall;
        int          reqs;
        int          accepts;
    } sb_item_t;

    sb_item_t    sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_rd  = '0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [3:0] acc, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(w >> (8 * off));
        h = off[1] ? w[31:16] : w[15:0];
        case (acc)
            4'd1:    r = {{24{b[7]}}, b};
            4'd4:    r = {24'd0, b};
            4'd2:    r = {{16{h[15]}}, h};
            4'd5:    r = {16'd0, h};
            4'd3:    r = w;
            default: r = '0;
        endcase
        return r;
    endfunction

    // One line per completed access; request fields are checked on every mem_req cycle.
    sb_item_t mon_it;
    int       stall_cnt = 0;
    int       req_cnt   = 0;
    int       acc_cnt   = 0;
    logic     stall_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            stall_cnt  = 0;
            req_cnt    = 0;
            acc_cnt    = 0;
            stall_prev = 1'b0;
        end else begin
            if (mem_req) begin
                req_cnt++;
                if (mem_ready) acc_cnt++;
                if (sb.size() > 0) begin
                    chk_eq("req_addr", mem_addr, sb[0].addr);
                    chk_eq("req_we", 32'(mem_we), 32'(sb[0].we));
                    chk_eq("req_wstrb", 32'(mem_wstrb), 32'(sb[0].wstrb));
                    if (sb[0].we) chk_eq("req_wdata", mem_wdata, sb[0].wdata);
                end
            end
            if (stall_req) begin
                stall_cnt++;
            end else if (stall_prev) begin
                if (sb.size() == 0) begin
                    chk_eq("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    mon_it = sb.pop_front();
                    chk_eq("rd_data", rd_data_out, mon_it.rd);
                    chk_eq("bus_err", 32'(bus_err), 32'(mon_it.bus_err));
                    chk_eq("stall_cycles", stall_cnt, mon_it.stall);
                    chk_eq("req_cycles", req_cnt, mon_it.reqs);
                    chk_eq("accepts", acc_cnt, mon_it.accepts);
`ifdef MEM_MISALIGN_CHK_EN
                    chk_eq("misalign_err", 32'(misalign_err), 32'(mon_it.mis));
`endif
                    $display("[TB] done addr=0x%08h rd=0x%08h stall=%0d reqs=%0d bus_err=%0b",
                             mon_it.addr, rd_data_out, stall_cnt, req_cnt, bus_err);
                end
                stall_cnt = 0;
                req_cnt   = 0;
                acc_cnt   = 0;
            end
            stall_prev = stall_req;
        end
    end

    // rvalid_dly < 0 means memory never answers (timeout path).
    task automatic run_access(input logic [3:0] acc, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdata, input int ready_dly, input int rvalid_dly,
                              input int hold, input bit mis);
        sb_item_t    it;
        logic [1:0]  off;
        int          n;
        off        = addr[1:0];
        it.addr    = {addr[31:2], 2'b00};
        it.we      = (acc >= 4'd6);
        it.mis     = mis;
        it.bus_err = (rvalid_dly < 0) && !mis;
        case (acc)
            4'd6:    begin it.wstrb = 4'b0001 << off; it.wdata = {4{wd[7:0]}}; end
            4'd7:    begin it.wstrb = off[1] ? 4'b1100 : 4'b0011; it.wdata = {2{wd[15:0]}}; end
            4'd8:    begin it.wstrb = 4'hF; it.wdata = wd; end
            default: begin it.wstrb = 4'h0; it.wdata = '0; end
        endcase
        if (mis || rvalid_dly < 0) exp_rd = '0;
        else if (acc <= 4'd5)      exp_rd = model_load(acc, off, rdata);
        it.rd      = exp_rd;
        it.stall   = mis ? 1 : 3 + ready_dly + ((rvalid_dly < 0) ? 254 : rvalid_dly);
        it.reqs    = mis ? 0 : ready_dly + 1;
        it.accepts = mis ? 0 : 1;
        sb.push_back(it);

        valid_in  = 1'b1;
        access_in = acc;
        we_in     = it.we;
        addr_in   = addr;
        wd_in     = wd;
        @(posedge clk); #1;
        if (!mis) begin
            n = 0;
            while (!mem_req && n < 8) begin @(posedge clk); #1; n++; end
            if (n == 8) chk_eq("req_seen", 32'(mem_req), 32'd1);
            repeat (ready_dly) begin @(posedge clk); #1; end
            mem_ready = 1'b1;
            @(posedge clk); #1;
            mem_ready = 1'b0;
            if (rvalid_dly >= 0) begin
                repeat (rvalid_dly) begin @(posedge clk); #1; end
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
        end
        n = 0;
        while (stall_req && n < 400) begin @(posedge clk); #1; n++; end
        if (n == 400) chk_eq("done_seen", 32'(stall_req), 32'd0);
        // Held in DONE: no reissue, no stall, error pulse already gone.
        repeat (hold) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk_eq("hold_stall", 32'(stall_req), 32'd0);
            chk_eq("hold_req", 32'(mem_req), 32'd0);
            chk_eq("hold_bus_err", 32'(bus_err), 32'd0);
            @(posedge clk); #1;
        end
        pipe_adv = 1'b1;
        @(posedge clk); #1;
        pipe_adv  = 1'b0;
        valid_in  = 1'b0;
        access_in = 4'd0;
    endtask

    task automatic run_nop(input logic v, input logic [3:0] acc);
        valid_in  = v;
        access_in = acc;
        we_in     = 1'b0;
        addr_in   = $urandom;
        @(negedge clk);
        chk_eq("nop_stall", 32'(stall_req), 32'd0);
        chk_eq("nop_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk_eq("nop_req2", 32'(mem_req), 32'd0);
        chk_eq("nop_rd", rd_data_out, exp_rd);
        $display("[TB] nop valid=%0b acc=%0d stall=%0b req=%0b", v, acc, stall_req, mem_req);
        @(posedge clk); #1;
        valid_in  = 1'b0;
        access_in = 4'd0;
    endtask

    initial begin
        rst        = 1'b1;
        valid_in   = 1'b0;
        access_in  = 4'd0;
        we_in      = 1'b0;
        addr_in    = '0;
        wd_in      = '0;
        pipe_adv   = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_stall", 32'(stall_req), 32'd0);
        chk_eq("rst_req", 32'(mem_req), 32'd0);
        chk_eq("rst_rd", rd_data_out, 32'd0);
        chk_eq("rst_bus_err", 32'(bus_err), 32'd0);
        chk_eq("rst_addr", mem_addr, 32'd0);
        chk_eq("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk_eq("rst_we", 32'(mem_we), 32'd0);
        $display("[TB] reset stall=%0b req=%0b rd=0x%08h", stall_req, mem_req, rd_data_out);
        @(posedge clk); #1;
        rst = 1'b0;

        run_access(4'd3, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 1'b0);
        run_access(4'd1, 32'h0000_1003, 32'h0,        32'h80FF_FF7F, 0, 0, 0, 1'b0);
        run_access(4'd4, 32'h0000_1003, 32'h0,        32'h80FF_FF7F, 0, 0, 0, 1'b0);
        run_access(4'd5, 32'h0000_1002, 32'h0,        32'h80FF_FF7F, 0, 0, 0, 1'b0);
        run_access(4'd2, 32'h0000_1000, 32'h0,        32'h80FF_FF7F, 0, 1, 0, 1'b0);
        run_access(4'd1, 32'h0000_1000, 32'h0,        32'h80FF_FF7F, 1, 0, 0, 1'b0);
        run_access(4'd7, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        0, 0, 0, 1'b0);
        run_access(4'd6, 32'h0000_2001, 32'h5566_77EF, 32'h0,        0, 2, 0, 1'b0);
        run_access(4'd8, 32'h0000_2004, 32'hA5A5_0F0F, 32'h0,        0, 0, 0, 1'b0);
        run_access(4'd3, 32'h0000_4008, 32'h0,        32'h0BAD_F00D, 5, 2, 2, 1'b0);

        run_nop(1'b1, 4'd0);
        run_nop(1'b1, 4'd9);
        run_nop(1'b1, 4'd15);
        run_nop(1'b0, 4'd3);

`ifdef MEM_MISALIGN_CHK_EN
        run_access(4'd3, 32'h0000_1001, 32'h0,        32'h1234_5678, 0, 0, 1, 1'b1);
        run_access(4'd7, 32'h0000_2003, 32'hFFFF_1111, 32'h0,        0, 0, 0, 1'b1);
        run_access(4'd5, 32'h0000_1002, 32'h0,        32'h9876_5432, 0, 0, 0, 1'b0);
`else
        run_access(4'd2, 32'h0000_1001, 32'h0,        32'h1234_8001, 0, 0, 0, 1'b0);
        run_access(4'd3, 32'h0000_1002, 32'h0,        32'h1357_9BDF, 0, 0, 0, 1'b0);
`endif

        run_access(4'd3, 32'h0000_5000, 32'h0,        32'hFFFF_FFFF, 0, -1, 2, 1'b0);

        // Reset in WAIT abandons the access; a late rvalid must be ignored.
        valid_in  = 1'b1;
        access_in = 4'd3;
        we_in     = 1'b0;
        addr_in   = 32'h0000_3000;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst      = 1'b1;
        valid_in = 1'b0;
        @(posedge clk); #1;
        rst    = 1'b0;
        exp_rd = '0;
        repeat (2) begin @(posedge clk); #1; end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk_eq("rstw_stall", 32'(stall_req), 32'd0);
        chk_eq("rstw_req", 32'(mem_req), 32'd0);
        chk_eq("rstw_rd", rd_data_out, exp_rd);
        chk_eq("rstw_bus_err", 32'(bus_err), 32'd0);
        chk_eq("rstw_addr", mem_addr, 32'd0);
        $display("[TB] reset-in-wait stall=%0b req=%0b rd=0x%08h", stall_req, mem_req, rd_data_out);

        run_access(4'd4, 32'h0000_6001, 32'h0,        32'h0000_9C00, 0, 0, 0, 1'b0);

        repeat (3) @(posedge clk);
        chk_eq("sb_left", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
